alu_ctrl_stage: RTL and testbench

//  ID-stage ALU control decoder plus ID/EX control register for the pipeline processor.
//  - Decodes a 32-bit MIPS instruction into the 4-bit ALU opcode consumed by the EX-stage ALU, plus operand-select controls.
//  - Registers the decoded controls into ID/EX with stall-hold and flush-to-bubble.
//  - Is the producing end of the ALUOp interface; the ALU consumes o_ALUOp one cycle after decode.

---
 rtl/alu_ctrl_stage.sv | 138 +++++++++++++
 tb/tb_alu_ctrl_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: ID-stage ALU control decoder feeding the ID/EX control register.
// Decodes a MIPS instruction word into the EX-stage ALU opcode and operand selects.
// The ID/EX register holds on stall and loads a bubble on flush or an invalid slot.
// Optional feature macro: ALU_CTRL_ILLEGAL_EN (registered undecodable-instruction flag).
// Without it, o_Illegal is tied low.
module alu_ctrl_stage #(
  parameter logic [3:0] BUBBLE_OP = 4'h0
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [31:0] i_Instruction,
  input  logic        i_Valid,
  input  logic        i_Stall,
  input  logic        i_Flush,
  output logic [3:0]  o_ALUOp,
  output logic        o_ALUSrc1,
  output logic        o_ALUSrc2,
  output logic        o_ExtOp,
  output logic        o_LuiOp,
  output logic [4:0]  o_Shamt,
  output logic        o_Valid,
  output logic        o_Illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [3:0] dec_aluop;
  logic       dec_src1;
  logic       dec_src2;
  logic       dec_ext;
  logic       dec_lui;
`ifdef ALU_CTRL_ILLEGAL_EN
  logic       dec_illegal;
`endif

  assign opcode = i_Instruction[31:26];
  assign funct  = i_Instruction[5:0];

  // Combinational decode of opcode/funct into ALU opcode and operand selects
  always_comb begin
    dec_aluop = 4'h0;
    dec_src1  = 1'b0;
    dec_src2  = 1'b0;
    dec_ext   = 1'b0;
    dec_lui   = 1'b0;
`ifdef ALU_CTRL_ILLEGAL_EN
    dec_illegal = 1'b0;
`endif
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: dec_aluop = 4'h0;
          6'h22, 6'h23: dec_aluop = 4'h1;
          6'h24:        dec_aluop = 4'h3;
          6'h25:        dec_aluop = 4'h4;
          6'h26:        dec_aluop = 4'h5;
          6'h27:        dec_aluop = 4'h6;
          6'h2A:        dec_aluop = 4'h8;
          6'h2B:        dec_aluop = 4'h7;
          6'h00: begin dec_aluop = 4'h9; dec_src1 = 1'b1; end
          6'h02: begin dec_aluop = 4'hA; dec_src1 = 1'b1; end
          6'h03: begin dec_aluop = 4'hB; dec_src1 = 1'b1; end
          6'h04:        dec_aluop = 4'h9;
          6'h06:        dec_aluop = 4'hA;
          6'h07:        dec_aluop = 4'hB;
          6'h08, 6'h09: dec_aluop = 4'h0;
          default: begin
`ifdef ALU_CTRL_ILLEGAL_EN
            dec_illegal = 1'b1;
`endif
          end
        endcase
      end
      6'h08, 6'h09: begin dec_aluop = 4'h0; dec_src2 = 1'b1; dec_ext = 1'b1; end
      6'h0A:        begin dec_aluop = 4'h8; dec_src2 = 1'b1; dec_ext = 1'b1; end
      6'h0B:        begin dec_aluop = 4'h7; dec_src2 = 1'b1; dec_ext = 1'b1; end
      6'h0C:        begin dec_aluop = 4'h3; dec_src2 = 1'b1; end
      6'h0D:        begin dec_aluop = 4'h4; dec_src2 = 1'b1; end
      6'h0E:        begin dec_aluop = 4'h5; dec_src2 = 1'b1; end
      6'h0F:        begin dec_aluop = 4'h0; dec_src2 = 1'b1; dec_lui = 1'b1; end
      6'h23, 6'h2B: begin dec_aluop = 4'h0; dec_src2 = 1'b1; dec_ext = 1'b1; end
      6'h04, 6'h05: dec_aluop = 4'h1;
      // blez and bgtz share the gtz opcode; the branch unit inverts for blez
      6'h06, 6'h07: dec_aluop = 4'hC;
      6'h02, 6'h03: dec_aluop = 4'h0;
      default: begin
`ifdef ALU_CTRL_ILLEGAL_EN
        dec_illegal = 1'b1;
`endif
      end
    endcase
  end

  // ID/EX control register: flush beats stall, stall holds, invalid slot loads a bubble
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_ALUOp   <= BUBBLE_OP;
      o_ALUSrc1 <= 1'b0;
      o_ALUSrc2 <= 1'b0;
      o_ExtOp   <= 1'b0;
      o_LuiOp   <= 1'b0;
      o_Shamt   <= 5'd0;
      o_Valid   <= 1'b0;
    end else if (i_Flush || (!i_Stall && !i_Valid)) begin
      o_ALUOp   <= BUBBLE_OP;
      o_ALUSrc1 <= 1'b0;
      o_ALUSrc2 <= 1'b0;
      o_ExtOp   <= 1'b0;
      o_LuiOp   <= 1'b0;
      o_Shamt   <= 5'd0;
      o_Valid   <= 1'b0;
    end else if (!i_Stall) begin
      o_ALUOp   <= dec_aluop;
      o_ALUSrc1 <= dec_src1;
      o_ALUSrc2 <= dec_src2;
      o_ExtOp   <= dec_ext;
      o_LuiOp   <= dec_lui;
      o_Shamt   <= i_Instruction[10:6];
      o_Valid   <= 1'b1;
    end
  end

`ifdef ALU_CTRL_ILLEGAL_EN
  // Illegal flag tracks o_Valid's load/hold/bubble behaviour
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Illegal <= 1'b0;
    end else if (i_Flush || (!i_Stall && !i_Valid)) begin
      o_Illegal <= 1'b0;
    end else if (!i_Stall) begin
      o_Illegal <= dec_illegal;
    end
  end
`else
  assign o_Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb_alu_ctrl_stage: directed and randomized checks of alu_ctrl_stage against a
// table-driven reference model of the ID/EX control register.
module tb_alu_ctrl_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        valid_in;
  logic        stall;
  logic        flush;
  logic [3:0]  alu_op;
  logic        src1;
  logic        src2;
  logic        ext_op;
  logic        lui_op;
  logic [4:0]  shamt;
  logic        valid_out;
  logic        illegal;

  int num_compared;
  int num_mismatched;

  // Reference decode tables indexed by funct (R-type) or opcode; -1 = undecodable
  int r_code[64];
  bit r_by_shamt[64];
  int i_code[64];
  bit i_imm[64];
  bit i_sext[64];
  bit i_lui[64];

  // Expected ID/EX register contents
  int m_aluop;
  bit m_src1, m_src2, m_ext, m_lui, m_valid, m_illegal;
  int m_shamt;

  byte unsigned legal_ops[16] = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
                                  8'h23, 8'h2B, 8'h04, 8'h05, 8'h06, 8'h07, 8'h02, 8'h03};
  byte unsigned legal_functs[18] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
                                     8'h2A, 8'h2B, 8'h00, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07,
                                     8'h08, 8'h09};

  alu_ctrl_stage #(.BUBBLE_OP(4'h0)) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .i_Instruction(instr),
    .i_Valid(valid_in),
    .i_Stall(stall),
    .i_Flush(flush),
    .o_ALUOp(alu_op),
    .o_ALUSrc1(src1),
    .o_ALUSrc2(src2),
    .o_ExtOp(ext_op),
    .o_LuiOp(lui_op),
    .o_Shamt(shamt),
    .o_Valid(valid_out),
    .o_Illegal(illegal)
  );

  // Free-running 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_compared++;
    if (observed !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic fillTables();
    for (int k = 0; k < 64; k++) begin
      r_code[k] = -1; r_by_shamt[k] = 0;
      i_code[k] = -1; i_imm[k] = 0; i_sext[k] = 0; i_lui[k] = 0;
    end
    r_code['h20] = 0; r_code['h21] = 0; r_code['h22] = 1; r_code['h23] = 1;
    r_code['h24] = 3; r_code['h25] = 4; r_code['h26] = 5; r_code['h27] = 6;
    r_code['h2A] = 8; r_code['h2B] = 7;
    r_code['h00] = 9; r_code['h02] = 10; r_code['h03] = 11;
    r_by_shamt['h00] = 1; r_by_shamt['h02] = 1; r_by_shamt['h03] = 1;
    r_code['h04] = 9; r_code['h06] = 10; r_code['h07] = 11;
    r_code['h08] = 0; r_code['h09] = 0;
    i_code['h08] = 0; i_code['h09] = 0; i_code['h0A] = 8; i_code['h0B] = 7;
    i_code['h23] = 0; i_code['h2B] = 0;
    foreach (legal_ops[k]) if (legal_ops[k] inside {8'h08, 8'h09, 8'h0A, 8'h0B, 8'h23, 8'h2B}) begin
      i_imm[legal_ops[k]] = 1; i_sext[legal_ops[k]] = 1;
    end
    i_code['h0C] = 3; i_code['h0D] = 4; i_code['h0E] = 5; i_code['h0F] = 0;
    i_imm['h0C] = 1; i_imm['h0D] = 1; i_imm['h0E] = 1; i_imm['h0F] = 1; i_lui['h0F] = 1;
    i_code['h04] = 1; i_code['h05] = 1; i_code['h06] = 12; i_code['h07] = 12;
    i_code['h02] = 0; i_code['h03] = 0;
  endtask

  task automatic modelBubble();
    m_aluop = 0; m_src1 = 0; m_src2 = 0; m_ext = 0; m_lui = 0;
    m_shamt = 0; m_valid = 0; m_illegal = 0;
  endtask

  task automatic modelLoad(input logic [31:0] w);
    int op, fn, code;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    modelBubble();
    if (op == 0) begin
      code = r_code[fn];
      m_src1 = r_by_shamt[fn];
    end else begin
      code = i_code[op];
      m_src2 = i_imm[op]; m_ext = i_sext[op]; m_lui = i_lui[op];
    end
    m_aluop = (code < 0) ? 0 : code;
`ifdef ALU_CTRL_ILLEGAL_EN
    m_illegal = (code < 0);
`endif
    m_shamt = int'(w[10:6]);
    m_valid = 1;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".aluop"}, 32'(alu_op), 32'(m_aluop));
    checkOutput({tag, ".src1"}, 32'(src1), 32'(m_src1));
    checkOutput({tag, ".src2"}, 32'(src2), 32'(m_src2));
    checkOutput({tag, ".ext"}, 32'(ext_op), 32'(m_ext));
    checkOutput({tag, ".lui"}, 32'(lui_op), 32'(m_lui));
    checkOutput({tag, ".shamt"}, 32'(shamt), 32'(m_shamt));
    checkOutput({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
    checkOutput({tag, ".illegal"}, 32'(illegal), 32'(m_illegal));
  endtask

  // Drive one cycle of inputs, advance the model with the same inputs, compare just after the edge
  task automatic applyStimulus(input string tag, input logic [31:0] w, input logic v,
                               input logic s, input logic f);
    instr = w; valid_in = v; stall = s; flush = f;
    @(posedge clk);
    if (f) modelBubble();
    else if (s) begin end
    else if (!v) modelBubble();
    else modelLoad(w);
    #1;
    checkAll(tag);
  endtask

  function automatic logic [31:0] randomInstr();
    logic [31:0] w;
    int pick;
    w = $urandom;
    pick = $urandom_range(0, 9);
    if (pick < 4) begin
      w[31:26] = 6'h00;
      w[5:0] = 6'(legal_functs[$urandom_range(0, 17)]);
    end else if (pick < 8) begin
      w[31:26] = 6'(legal_ops[$urandom_range(0, 15)]);
    end else if (pick == 8) begin
      w = 32'h0;
    end
    return w;
  endfunction

  // Main sequence: reset, directed cases, async reset, then randomized traffic
  initial begin
    num_compared = 0;
    num_mismatched = 0;
    fillTables();
    rst = 1'b1; instr = 32'h0; valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
    modelBubble();
    #1;
    checkAll("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    applyStimulus("idle", 32'h0, 1'b0, 1'b0, 1'b0);

    applyStimulus("sub", 32'h00851022, 1'b1, 1'b0, 1'b0);
    checkOutput("sub.const_op", 32'(alu_op), 32'h1);
    applyStimulus("sra", 32'h00041083, 1'b1, 1'b0, 1'b0);
    checkOutput("sra.const_op", 32'(alu_op), 32'hB);
    checkOutput("sra.const_shamt", 32'(shamt), 32'h2);
    applyStimulus("lui", 32'h3C01ABCD, 1'b1, 1'b0, 1'b0);
    checkOutput("lui.const_lui", 32'(lui_op), 32'h1);
    applyStimulus("ori", 32'h3421FFFF, 1'b1, 1'b0, 1'b0);
    checkOutput("ori.const_op", 32'(alu_op), 32'h4);
    checkOutput("ori.const_ext", 32'(ext_op), 32'h0);
    applyStimulus("nop", 32'h00000000, 1'b1, 1'b0, 1'b0);
    checkOutput("nop.const_op", 32'(alu_op), 32'h9);
    checkOutput("nop.const_valid", 32'(valid_out), 32'h1);
    applyStimulus("sub2", 32'h00851022, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus("stall", 32'h3421FFFF, 1'b1, 1'b1, 1'b0);
    checkOutput("stall.const_op", 32'(alu_op), 32'h1);
    applyStimulus("stallflush", 32'h3421FFFF, 1'b1, 1'b1, 1'b1);
    checkOutput("stallflush.const_valid", 32'(valid_out), 32'h0);
    applyStimulus("illegal", 32'hFC000000, 1'b1, 1'b0, 1'b0);
`ifdef ALU_CTRL_ILLEGAL_EN
    checkOutput("illegal.const_flag", 32'(illegal), 32'h1);
`else
    checkOutput("illegal.const_flag", 32'(illegal), 32'h0);
`endif
    checkOutput("illegal.const_op", 32'(alu_op), 32'h0);

    applyStimulus("pre_areset", 32'h00041083, 1'b1, 1'b0, 1'b0);
    applyStimulus("areset_stall", 32'h3C01ABCD, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    modelBubble();
    #1;
    checkAll("areset");
    #1;
    rst = 1'b0;
    applyStimulus("after_areset", 32'h3C01ABCD, 1'b1, 1'b1, 1'b0);

    for (int n = 0; n < 400; n++) begin
      applyStimulus("rand", randomInstr(), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 2),
                    ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
